// File: rtl/mempool_pkg.sv
// Shared DMA request/status types and chunk-size constants for the mempool DMA path.
package mempool_pkg;

  localparam int unsigned NumDmasPerSubGroup = 4;
  localparam int unsigned DmaChunkBytes      = 1024;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] num_bytes;
    logic [3:0]  id;
    logic [3:0]  cache;
    logic [1:0]  burst;
    logic        decouple_rw;
    logic        deburst;
    logic        serialize;
  } dma_req_t;

  typedef struct packed {
    logic trans_complete;
  } dma_meta_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSplit = 2'd1,
    StDrain = 2'd2
  } split_state_e;

  // Largest chunk that neither exceeds the remaining bytes nor crosses a dst chunk boundary.
  function automatic logic [31:0] chunk_len(input logic [31:0] remaining,
                                            input logic [31:0] dst,
                                            input logic [31:0] chunk_bytes);
    logic [31:0] room;
    room = chunk_bytes - (dst & (chunk_bytes - 32'd1));
    return (remaining < room) ? remaining : room;
  endfunction

endpackage

// File: rtl/dma_backend_tracker.sv
// Per-backend outstanding-chunk counters and the resulting dispatch eligibility.
module dma_backend_tracker
  import mempool_pkg::*;
#(
  parameter int unsigned NumBackends    = NumDmasPerSubGroup,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumBackends-1:0] dispatch_i,
  input  logic [NumBackends-1:0] complete_i,
  output logic [NumBackends-1:0] eligible_o,
  output logic                   all_idle_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [CntW-1:0] cnt_q [NumBackends];

  // A completion against an empty counter is stale (e.g. aborted by reset) and is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumBackends; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumBackends; i++) begin
        if (dispatch_i[i] && !(complete_i[i] && cnt_q[i] != '0))
          cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (!dispatch_i[i] && complete_i[i] && cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    eligible_o = '0;
    all_idle_o = 1'b1;
    for (int unsigned i = 0; i < NumBackends; i++) begin
      eligible_o[i] = (cnt_q[i] < MaxCnt);
      if (cnt_q[i] != '0) all_idle_o = 1'b0;
    end
  end

endmodule

// File: rtl/dma_req_splitter.sv
// Splits a frontend DMA transfer into dst-aligned chunks dispatched round-robin to backends.
// Optional dispatch statistics counter enabled by defining DMA_SPLITTER_STATS_EN.
module dma_req_splitter
  import mempool_pkg::*;
#(
  parameter int unsigned NumBackends    = NumDmasPerSubGroup,
  parameter int unsigned ChunkBytes     = DmaChunkBytes,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  dma_req_t               req_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output dma_req_t               be_req_o [NumBackends],
  output logic [NumBackends-1:0] be_valid_o,
  input  logic [NumBackends-1:0] be_ready_i,
  input  dma_meta_t              be_meta_i [NumBackends],
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            stat_chunks_o
);

  localparam int unsigned PtrW = (NumBackends > 1) ? $clog2(NumBackends) : 1;

  split_state_e           state_q;
  dma_req_t               cur_q;
  logic [PtrW-1:0]        rr_q, held_tgt_q, tgt;
  logic                   held_q, found, dispatching, fire, all_idle;
  logic [NumBackends-1:0] eligible, complete, handshake;
  logic [31:0]            len;
  dma_req_t               chunk;
  int unsigned            idx;

  assign len = chunk_len(cur_q.num_bytes, cur_q.dst, 32'(ChunkBytes));

  always_comb begin
    chunk           = cur_q;
    chunk.num_bytes = len;
  end

  // A presented-but-unaccepted target is held so be_req_o cannot move under a stalled backend;
  // its counter can only fall meanwhile, so it stays eligible.
  always_comb begin
    found = 1'b0;
    tgt   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NumBackends; k++) begin
      idx = (32'(rr_q) + k) % NumBackends;
      if (!found && eligible[PtrW'(idx)]) begin
        found = 1'b1;
        tgt   = PtrW'(idx);
      end
    end
    if (held_q) begin
      found = 1'b1;
      tgt   = held_tgt_q;
    end
  end

  assign dispatching = (state_q == StSplit) && (cur_q.num_bytes != '0) && found;
  assign fire        = dispatching && be_ready_i[tgt];

  always_comb begin
    be_valid_o = '0;
    complete   = '0;
    for (int unsigned i = 0; i < NumBackends; i++) begin
      be_req_o[i]   = '0;
      complete[i]   = be_meta_i[i].trans_complete;
      if (dispatching && tgt == PtrW'(i)) begin
        be_valid_o[i] = 1'b1;
        be_req_o[i]   = chunk;
      end
    end
  end

  assign handshake = be_valid_o & be_ready_i;

  dma_backend_tracker #(
    .NumBackends   (NumBackends),
    .MaxOutstanding(MaxOutstanding)
  ) u_tracker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .dispatch_i(handshake),
    .complete_i(complete),
    .eligible_o(eligible),
    .all_idle_o(all_idle)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      rr_q       <= '0;
      held_q     <= 1'b0;
      held_tgt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            cur_q   <= req_i;
            state_q <= StSplit;
          end
        end
        StSplit: begin
          if (cur_q.num_bytes == '0) begin
            state_q <= StDrain;
          end else if (fire) begin
            cur_q.src       <= cur_q.src + len;
            cur_q.dst       <= cur_q.dst + len;
            cur_q.num_bytes <= cur_q.num_bytes - len;
            rr_q            <= (tgt == PtrW'(NumBackends - 1)) ? '0 : tgt + 1'b1;
            held_q          <= 1'b0;
            if (cur_q.num_bytes == len) state_q <= StDrain;
          end else if (dispatching) begin
            held_q     <= 1'b1;
            held_tgt_q <= tgt;
          end
        end
        StDrain: begin
          if (all_idle) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle) && !rst_i;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDrain) && all_idle;

`ifdef DMA_SPLITTER_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     stat_q <= '0;
    else if (fire) stat_q <= stat_q + 32'd1;
  end

  assign stat_chunks_o = stat_q;
`else
  assign stat_chunks_o = '0;
`endif

endmodule

// File: tb/tb_dma_req_splitter.sv
// Self-checking bench for dma_req_splitter: directed scenarios plus a randomized run against a queue model.
module tb_dma_req_splitter;
  import mempool_pkg::*;

`ifdef DMA_SPLITTER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_req_t  a_req;
  logic      a_req_valid, a_req_ready;
  dma_req_t  a_be_req [4];
  logic [3:0] a_be_valid, a_be_ready;
  dma_meta_t a_meta [4];
  logic      a_busy, a_done;
  logic [31:0] a_stat;

  dma_req_t  b_req;
  logic      b_req_valid, b_req_ready;
  dma_req_t  b_be_req [2];
  logic [1:0] b_be_valid, b_be_ready;
  dma_meta_t b_meta [2];
  logic      b_busy, b_done;
  logic [31:0] b_stat;

  dma_req_splitter #(.NumBackends(4), .ChunkBytes(1024), .MaxOutstanding(4)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .be_req_o(a_be_req), .be_valid_o(a_be_valid), .be_ready_i(a_be_ready), .be_meta_i(a_meta),
    .busy_o(a_busy), .done_o(a_done), .stat_chunks_o(a_stat)
  );

  dma_req_splitter #(.NumBackends(2), .ChunkBytes(1024), .MaxOutstanding(1)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .be_req_o(b_be_req), .be_valid_o(b_be_valid), .be_ready_i(b_be_ready), .be_meta_i(b_meta),
    .busy_o(b_busy), .done_o(b_done), .stat_chunks_o(b_stat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_meta();
    for (int i = 0; i < 4; i++) a_meta[i] = '0;
    for (int i = 0; i < 2; i++) b_meta[i] = '0;
  endtask

  task automatic idle_inputs();
    a_req = '0; a_req_valid = 1'b0; a_be_ready = '0;
    b_req = '0; b_req_valid = 1'b0; b_be_ready = '0;
    clr_meta();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_during: got %b want 0", a_req_ready); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", a_req_ready); end
    checks++; if ({a_busy, a_done, a_be_valid} !== 6'b0) begin errors++; $display("FAIL rst_outputs: got %b want 0", {a_busy, a_done, a_be_valid}); end
    checks++; if (a_stat !== 32'd0) begin errors++; $display("FAIL rst_stat: got %0d want 0", a_stat); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_be_req[i] !== '0) begin errors++; $display("FAIL rst_be_req%0d: got %h want 0", i, a_be_req[i]); end
    end
    checks++; if (b_req_ready !== 1'b1 || b_be_valid !== 2'b0) begin errors++; $display("FAIL rst_b: got %b/%b want 1/00", b_req_ready, b_be_valid); end
    tick();
  endtask

  task automatic test_split_example();
    dma_req_t r, e;
    logic [31:0] es [3], ed [3], el [3];
    es[0] = 32'h8000_0000; ed[0] = 32'h100; el[0] = 32'h300;
    es[1] = 32'h8000_0300; ed[1] = 32'h400; el[1] = 32'h400;
    es[2] = 32'h8000_0700; ed[2] = 32'h800; el[2] = 32'h200;
    do_reset();
    r = '0; r.src = 32'h8000_0000; r.dst = 32'h100; r.num_bytes = 32'h900;
    r.id = 4'h5; r.cache = 4'h3; r.burst = 2'h1; r.decouple_rw = 1'b1; r.serialize = 1'b1;
    a_req = r; a_req_valid = 1'b1; a_be_ready = 4'hF;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL ex_req_ready: got %b want 1", a_req_ready); end
    tick();
    a_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = r; e.src = es[i]; e.dst = ed[i]; e.num_bytes = el[i];
      checks++; if (a_be_valid !== 4'(1 << i)) begin errors++; $display("FAIL ex_valid%0d: got %b want %b", i, a_be_valid, 4'(1 << i)); end
      checks++; if (a_be_req[i] !== e) begin errors++; $display("FAIL ex_chunk%0d: got %h want %h", i, a_be_req[i], e); end
      checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL ex_ready_busy%0d: got %b want 0", i, a_req_ready); end
      tick();
    end
    @(negedge clk);
    checks++; if ({a_be_valid, a_done, a_busy} !== 6'b000001) begin errors++; $display("FAIL ex_drain: got %b want 000001", {a_be_valid, a_done, a_busy}); end
    for (int i = 0; i < 3; i++) a_meta[i].trans_complete = 1'b1;
    tick();
    clr_meta();
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL ex_done: got %b want 1", a_done); end
    checks++; if (a_stat !== (StatsEn ? 32'd3 : 32'd0)) begin errors++; $display("FAIL ex_stat: got %0d want %0d", a_stat, StatsEn ? 3 : 0); end
    tick();
    @(negedge clk);
    checks++; if (a_done !== 1'b0 || a_req_ready !== 1'b1) begin errors++; $display("FAIL ex_after_done: got done=%b ready=%b want 0/1", a_done, a_req_ready); end
    tick();
    a_be_ready = '0;
  endtask

  task automatic test_zero_bytes();
    do_reset();
    a_req = '0; a_req.dst = 32'h40; a_req_valid = 1'b1;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL zero_req_ready: got %b want 1", a_req_ready); end
    tick();
    a_req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({a_be_valid, a_done} !== 5'b0) begin errors++; $display("FAIL zero_t1: got %b want 0", {a_be_valid, a_done}); end
    tick();
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_be_valid !== 4'b0) begin errors++; $display("FAIL zero_done_t2: got done=%b valid=%b want 1/0000", a_done, a_be_valid); end
    tick();
    @(negedge clk);
    checks++; if (a_done !== 1'b0 || a_req_ready !== 1'b1) begin errors++; $display("FAIL zero_t3: got done=%b ready=%b want 0/1", a_done, a_req_ready); end
    tick();
  endtask

  task automatic test_stall();
    dma_req_t r, e0, e1;
    do_reset();
    r = '0; r.src = 32'h1000; r.dst = 32'h200; r.num_bytes = 32'h600; r.id = 4'hA;
    e0 = r; e0.num_bytes = 32'h200;
    e1 = r; e1.src = 32'h1200; e1.dst = 32'h400; e1.num_bytes = 32'h400;
    a_req = r; a_req_valid = 1'b1; a_be_ready = 4'h0;
    tick();
    a_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) a_meta[2].trans_complete = 1'b1;
      @(negedge clk);
      checks++; if (a_be_valid !== 4'b0001) begin errors++; $display("FAIL stall_valid%0d: got %b want 0001", i, a_be_valid); end
      checks++; if (a_be_req[0] !== e0) begin errors++; $display("FAIL stall_req%0d: got %h want %h", i, a_be_req[0], e0); end
      tick();
      clr_meta();
    end
    a_be_ready = 4'hF;
    @(negedge clk);
    checks++; if (a_be_valid !== 4'b0001) begin errors++; $display("FAIL stall_release: got %b want 0001", a_be_valid); end
    tick();
    @(negedge clk);
    checks++; if (a_be_valid !== 4'b0010 || a_be_req[1] !== e1) begin errors++; $display("FAIL stall_second: got %b %h want 0010 %h", a_be_valid, a_be_req[1], e1); end
    tick();
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL stall_drain_done: got %b want 0", a_done); end
    a_meta[0].trans_complete = 1'b1; a_meta[1].trans_complete = 1'b1;
    tick();
    clr_meta();
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", a_done); end
    tick();
    a_be_ready = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_req = '0; a_req.src = 32'h10; a_req.num_bytes = 32'hC00; a_req_valid = 1'b1; a_be_ready = 4'h1;
    tick();
    a_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_be_valid !== 4'b0001) begin errors++; $display("FAIL rmid_first: got %b want 0001", a_be_valid); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got %b want 0", a_req_ready); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({a_be_valid, a_busy, a_done, a_req_ready} !== 7'b0000001) begin errors++; $display("FAIL rmid_outputs: got %b want 0000001", {a_be_valid, a_busy, a_done, a_req_ready}); end
    checks++; if (a_be_req[1] !== '0 || a_stat !== 32'd0) begin errors++; $display("FAIL rmid_req_stat: got %h %0d want 0 0", a_be_req[1], a_stat); end
    a_meta[0].trans_complete = 1'b1;
    tick();
    clr_meta();
    a_req = '0; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL rmid_late_complete: got done=%b want 1", a_done); end
    tick();
    a_be_ready = '0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    a_req = '0; a_req.num_bytes = 32'h1400; a_req_valid = 1'b1; a_be_ready = 4'hF;
    tick();
    a_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (a_be_valid !== 4'(1 << (i % 4))) begin errors++; $display("FAIL same_valid%0d: got %b want %b", i, a_be_valid, 4'(1 << (i % 4))); end
      if (i == 4) begin
        checks++; if (a_stat !== (StatsEn ? 32'd4 : 32'd0)) begin errors++; $display("FAIL same_stat_before: got %0d want %0d", a_stat, StatsEn ? 4 : 0); end
        a_meta[0].trans_complete = 1'b1;
      end
      tick();
    end
    clr_meta();
    @(negedge clk);
    checks++; if (a_stat !== (StatsEn ? 32'd5 : 32'd0)) begin errors++; $display("FAIL same_stat_after: got %0d want %0d", a_stat, StatsEn ? 5 : 0); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL same_drain0: got %b want 0", a_done); end
    for (int i = 1; i < 4; i++) a_meta[i].trans_complete = 1'b1;
    tick();
    clr_meta();
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL same_b0_kept: got done=%b want 0", a_done); end
    a_meta[0].trans_complete = 1'b1;
    tick();
    clr_meta();
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL same_done: got %b want 1", a_done); end
    tick();
    a_be_ready = '0;
  endtask

  task automatic test_max_outstanding();
    int n_disp;
    n_disp = 0;
    do_reset();
    b_req = '0; b_req.num_bytes = 32'h1000; b_req_valid = 1'b1; b_be_ready = 2'b11;
    tick();
    b_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_disp += $countones(b_be_valid & b_be_ready);
      tick();
    end
    @(negedge clk);
    checks++; if (n_disp !== 2) begin errors++; $display("FAIL maxo_dispatches: got %0d want 2", n_disp); end
    checks++; if (b_be_valid !== 2'b00 || b_busy !== 1'b1) begin errors++; $display("FAIL maxo_blocked: got %b busy=%b want 00/1", b_be_valid, b_busy); end
    b_meta[1].trans_complete = 1'b1;
    tick();
    clr_meta();
    @(negedge clk);
    checks++; if (b_be_valid !== 2'b10 || b_be_req[1].dst !== 32'h800) begin errors++; $display("FAIL maxo_third: got %b dst=%h want 10 800", b_be_valid, b_be_req[1].dst); end
    tick();
    @(negedge clk);
    checks++; if (b_be_valid !== 2'b00) begin errors++; $display("FAIL maxo_blocked2: got %b want 00", b_be_valid); end
    b_meta[0].trans_complete = 1'b1;
    tick();
    clr_meta();
    @(negedge clk);
    checks++; if (b_be_valid !== 2'b01 || b_be_req[0].dst !== 32'hC00) begin errors++; $display("FAIL maxo_fourth: got %b dst=%h want 01 C00", b_be_valid, b_be_req[0].dst); end
    tick();
    @(negedge clk);
    b_meta[0].trans_complete = 1'b1; b_meta[1].trans_complete = 1'b1;
    tick();
    clr_meta();
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL maxo_done: got %b want 1", b_done); end
    tick();
    b_be_ready = '0;
  endtask

  // Model: chunk queue from the alignment rule, round-robin over backends with fewer than 4 in flight.
  task automatic test_random();
    dma_req_t r, e;
    logic [31:0] qs[$], qd[$], ql[$];
    logic [31:0] s, d, rem, room, l;
    int out [4];
    int rr, held, tgt, disp, c, phase;
    bit done_seen, all_zero;
    logic [3:0] exp_valid, rdy, comp;
    do_reset();
    for (int i = 0; i < 4; i++) out[i] = 0;
    rr = 0;
    for (int x = 0; x < 8; x++) begin
      r = '0;
      r.src = $urandom; r.dst = $urandom_range(0, 32'hFFF);
      r.num_bytes = (x == 2) ? 32'd0 : $urandom_range(1, 32'h1400);
      r.id = 4'($urandom); r.cache = 4'($urandom); r.burst = 2'($urandom);
      r.decouple_rw = 1'($urandom); r.deburst = 1'($urandom); r.serialize = 1'($urandom);
      s = r.src; d = r.dst; rem = r.num_bytes;
      while (rem != 0) begin
        room = 32'd1024 - (d % 32'd1024);
        l = (rem < room) ? rem : room;
        qs.push_back(s); qd.push_back(d); ql.push_back(l);
        s += l; d += l; rem -= l;
      end
      a_req = r; a_req_valid = 1'b1;
      @(negedge clk);
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rand_req_ready%0d: got %b want 1", x, a_req_ready); end
      tick();
      a_req_valid = 1'b0;
      phase = 0; held = -1; done_seen = 0;
      for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
        rdy = 4'($urandom);
        a_be_ready = rdy;
        for (int b = 0; b < 4; b++) begin
          comp[b] = ($urandom_range(0, 2) == 0);
          a_meta[b].trans_complete = comp[b];
        end
        @(negedge clk);
        exp_valid = '0; tgt = -1;
        all_zero = (out[0] == 0) && (out[1] == 0) && (out[2] == 0) && (out[3] == 0);
        if (phase == 0 && qd.size() > 0) begin
          if (held >= 0) tgt = held;
          else for (int k = 0; k < 4; k++) if (tgt < 0 && out[(rr + k) % 4] < 4) tgt = (rr + k) % 4;
          if (tgt >= 0) exp_valid[tgt] = 1'b1;
        end
        checks++; if (a_be_valid !== exp_valid) begin errors++; $display("FAIL rand_valid x%0d c%0d: got %b want %b", x, cyc, a_be_valid, exp_valid); end
        if (tgt >= 0) begin
          e = r; e.src = qs[0]; e.dst = qd[0]; e.num_bytes = ql[0];
          checks++; if (a_be_req[tgt] !== e) begin errors++; $display("FAIL rand_chunk x%0d c%0d: got %h want %h", x, cyc, a_be_req[tgt], e); end
        end
        checks++; if (a_done !== (phase == 1 && all_zero)) begin errors++; $display("FAIL rand_done x%0d c%0d: got %b want %b", x, cyc, a_done, (phase == 1 && all_zero)); end
        disp = -1;
        if (phase == 1 && all_zero) done_seen = 1;
        if (phase == 0) begin
          if (qd.size() == 0) phase = 1;
          else if (tgt >= 0 && rdy[tgt]) begin
            disp = tgt; rr = (tgt + 1) % 4; held = -1;
            void'(qs.pop_front()); void'(qd.pop_front()); void'(ql.pop_front());
            if (qd.size() == 0) phase = 1;
          end else if (tgt >= 0) held = tgt;
        end
        for (int b = 0; b < 4; b++) begin
          c = out[b];
          if (b == disp) out[b]++;
          if (comp[b] && c > 0) out[b]--;
        end
        tick();
      end
      if (!done_seen) begin
        checks++; errors++;
        $display("FAIL rand_timeout x%0d: got no done want done", x);
      end
      clr_meta(); a_be_ready = '0;
      @(negedge clk);
      checks++; if (a_req_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL rand_idle x%0d: got ready=%b busy=%b want 1/0", x, a_req_ready, a_busy); end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_split_example();
    test_zero_bytes();
    test_stall();
    test_reset_mid();
    test_same_cycle();
    test_max_outstanding();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_req_splitter.md
DMA_REQ_SPLITTER -- requirements
Module: dma_req_splitter

Interface
- REQ-001: Parameter NumBackends, default NumDmasPerSubGroup; number of DMA backends served.
- REQ-002: Parameter ChunkBytes, default 1024; maximum bytes per backend request, power of two, aligned to dst.
- REQ-003: Parameter MaxOutstanding, default 4; maximum in-flight chunks per backend.
- REQ-004: clk_i  in  1  single clock; all logic is on the rising edge.
- REQ-005: rst_i  in  1  reset, synchronous, active-high.
- REQ-006: req_i  in  dma_req_t  frontend transfer request.
- REQ-007: req_valid_i / req_ready_o  in/out  1  frontend valid/ready handshake.
- REQ-008: be_req_o  out  NumBackends x dma_req_t  per-backend chunk request.
- REQ-009: be_valid_o / be_ready_i  out/in  NumBackends  per-backend valid/ready.
- REQ-010: be_meta_i  in  NumBackends x dma_meta_t  backend status; trans_complete is a one-cycle pulse per finished chunk.
- REQ-011: busy_o  out  1  high whenever the state is not IDLE.
- REQ-012: done_o  out  1  one-cycle pulse when a frontend transfer has fully completed.
- REQ-013: stat_chunks_o  out  32  count of chunks dispatched (see Configuration).

Function
- REQ-014: FSM states are IDLE, SPLIT and DRAIN.
- REQ-015: In IDLE, req_ready_o=1; on req_valid_i&&req_ready_o, the block latches src, dst, num_bytes and all other fields, then moves to SPLIT.
- REQ-016: A latched num_bytes==0 goes directly to DRAIN with no dispatch.
- REQ-017: Chunk length len = min(remaining, ChunkBytes - (dst & (ChunkBytes-1))); arithmetic is 32-bit unsigned.
- REQ-018: Each chunk carries src/dst at their current offsets, num_bytes=len, and id, cache, burst, decouple_rw, deburst and serialize copied unchanged.
- REQ-019: In SPLIT, the target backend is the first index, searching round-robin from rr_ptr, whose outstanding count < MaxOutstanding.
  - Only the target's be_valid_o is asserted; be_req_o is stable while valid && !ready.
- REQ-020: On be_valid_o&&be_ready_i:
  - src += len; dst += len; remaining -= len;
  - that backend's outstanding count +1;
  - rr_ptr = target+1 mod NumBackends.
- REQ-021: When remaining reaches 0 on a handshake, the FSM goes to DRAIN in the next cycle.
- REQ-022: If no backend is eligible, no be_valid_o is asserted and the state holds.
- REQ-023: Outstanding counters update on trans_complete as follows:
  - A trans_complete pulse decrements its backend's counter.
  - A simultaneous dispatch and completion on the same backend leaves it unchanged.
  - A completion with a counter of 0 is ignored.
- REQ-024: In DRAIN, once all counters are 0, done_o=1 for one cycle and the FSM returns to IDLE; req_ready_o rises in the following cycle.
- REQ-025: req_ready_o=0 in SPLIT and DRAIN; a new request cannot overlap the current one.
- REQ-026: Single-chunk latency: a handshake in cycle t gives be_valid_o in cycle t+1.

Reset
- REQ-027: rst_i high, including mid-transfer, forces:
  - FSM=IDLE, rr_ptr=0, all counters=0, stat counter=0;
  - req_ready_o=0 during reset and 1 in the first cycle after;
  - be_valid_o=0, busy_o=0, done_o=0, be_req_o='0.
- REQ-028: Completions of chunks aborted by reset are ignored because the counters are at 0.

Configuration
- REQ-029: With macro DMA_SPLITTER_STATS_EN defined:
  - stat_chunks_o counts dispatch handshakes and wraps at 2^32;
  - it is never cleared except by reset.
- REQ-030: Without DMA_SPLITTER_STATS_EN, stat_chunks_o is tied to 0 and no counter flops exist.

Structure
- REQ-031: dma_req_t, dma_meta_t, NumDmasPerSubGroup and a new localparam DmaChunkBytes=1024 belong in mempool_pkg.
- REQ-032: One sub-module, dma_backend_tracker, holds the per-backend outstanding counters and the eligibility vector; the FSM and chunk arithmetic stay in the top module.

Verification
- REQ-033: NumBackends=4, ChunkBytes=0x400; dst=0x100, src=0x8000_0000, num_bytes=0x900, all ready, then completions -> three chunks, then done_o one pulse:
  - backend 0: len 0x300, dst 0x100, src 0x8000_0000;
  - backend 1: len 0x400, dst 0x400, src 0x8000_0300;
  - backend 2: len 0x200, dst 0x800, src 0x8000_0700.
- REQ-034: num_bytes=0 -> no be_valid_o; done_o pulses exactly 2 cycles after the handshake.
- REQ-035: MaxOutstanding=1, NumBackends=2, 4 chunks, no completions -> exactly 2 dispatches; the third dispatch occurs only after a trans_complete arrives.
- REQ-036: be_ready_i held 0 for 5 cycles on the target -> be_valid_o and be_req_o stable for all 5 cycles, with no switch of backend.
- REQ-037: rst_i asserted during SPLIT after 1 of 3 chunks -> all outputs at reset values next cycle; a late trans_complete leaves the counters at 0.
- REQ-038: Dispatch and trans_complete on backend 0 in the same cycle -> counter unchanged; with DMA_SPLITTER_STATS_EN, stat_chunks_o increments by 1.
